// File: rtl/shift_frame_rx.sv
// Framed serial receiver: start, direction, WIDTH data bits LSB-first, [parity], stop.
// Define SHIFT_FRAME_RX_PARITY_EN to add an even-parity bit ahead of the stop bit.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | line idle, waiting for a low start bit
// DIR     | next sample is the direction bit
// DATA    | shifting data bits into shreg_q[cnt_q]
// PARITY  | next sample is the even-parity bit (parity build only)
// STOP    | next sample is the stop bit; frame accepted or dropped
module shift_frame_rx #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_en,
   input  logic             sin,
   output logic             load,
   output logic [WIDTH-1:0] data_in,
   output logic             left_right,
   output logic             busy,
   output logic             frame_err,
   output logic [CNT_W-1:0] good_cnt
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DIR    = 3'd1,
      S_DATA   = 3'd2,
`ifdef SHIFT_FRAME_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] shreg_q;
   logic             dir_q;
   logic             load_q;
   logic [WIDTH-1:0] data_q;
   logic             lr_q;
   logic             busy_q;
   logic             err_q;
   logic [CNT_W-1:0] good_cnt_q;
   logic             frame_ok_d;

`ifdef SHIFT_FRAME_RX_PARITY_EN
   logic perr_q;

   always_comb begin
      frame_ok_d = sin & ~perr_q;
   end
`else
   always_comb begin
      frame_ok_d = sin;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         dir_q      <= 1'b0;
         load_q     <= 1'b0;
         data_q     <= '0;
         lr_q       <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         good_cnt_q <= '0;
`ifdef SHIFT_FRAME_RX_PARITY_EN
         perr_q     <= 1'b0;
`endif
      end else begin
         load_q <= 1'b0;
         err_q  <= 1'b0;
         if (bit_en) begin
            case (state_q)
               S_IDLE: begin
                  if (!sin) begin
                     state_q <= S_DIR;
                     busy_q  <= 1'b1;
`ifdef SHIFT_FRAME_RX_PARITY_EN
                     perr_q  <= 1'b0;
`endif
                  end
               end
               S_DIR: begin
                  dir_q   <= sin;
                  cnt_q   <= '0;
                  state_q <= S_DATA;
               end
               S_DATA: begin
                  shreg_q[cnt_q] <= sin;
                  cnt_q          <= cnt_q + 1'b1;
                  if (cnt_q == LAST_BIT) begin
`ifdef SHIFT_FRAME_RX_PARITY_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_STOP;
`endif
                  end
               end
`ifdef SHIFT_FRAME_RX_PARITY_EN
               S_PARITY: begin
                  // even parity: XOR over dir, data and parity bit must be 0
                  perr_q  <= ^{dir_q, shreg_q, sin};
                  state_q <= S_STOP;
               end
`endif
               S_STOP: begin
                  if (frame_ok_d) begin
                     load_q <= 1'b1;
                     data_q <= shreg_q;
                     lr_q   <= dir_q;
                     if (good_cnt_q != {CNT_W{1'b1}}) good_cnt_q <= good_cnt_q + 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign load       = load_q;
   assign data_in    = data_q;
   assign left_right = lr_q;
   assign busy       = busy_q;
   assign frame_err  = err_q;
   assign good_cnt   = good_cnt_q;

endmodule

// File: tb/tb_shift_frame_rx.sv
// Bench for shift_frame_rx: frame-level reference model with per-cycle output compare.
// Honours SHIFT_FRAME_RX_PARITY_EN to match the DUT build.
module tb_shift_frame_rx;

   localparam int WIDTH = 8;
   localparam int CNT_W = 8;
`ifdef SHIFT_FRAME_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             bit_en = 1'b0;
   logic             sin = 1'b1;
   logic             load;
   logic [WIDTH-1:0] data_in;
   logic             left_right;
   logic             busy;
   logic             frame_err;
   logic [CNT_W-1:0] good_cnt;

   shift_frame_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_en     (bit_en),
      .sin        (sin),
      .load       (load),
      .data_in    (data_in),
      .left_right (left_right),
      .busy       (busy),
      .frame_err  (frame_err),
      .good_cnt   (good_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_loads  = 0;

   logic             exp_load, exp_err, exp_lr, exp_busy;
   logic [WIDTH-1:0] exp_data;
   logic [CNT_W-1:0] exp_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_load = 1'b0;
      exp_err  = 1'b0;
      exp_lr   = 1'b0;
      exp_busy = 1'b0;
      exp_data = '0;
      exp_cnt  = '0;
   endtask

   // outputs are registered, so sample mid-cycle against the model
   always @(negedge clk) begin
      if (!rst) begin
         check("load", 32'(load), 32'(exp_load));
         check("frame_err", 32'(frame_err), 32'(exp_err));
         check("busy", 32'(busy), 32'(exp_busy));
         check("data_in", 32'(data_in), 32'(exp_data));
         check("left_right", 32'(left_right), 32'(exp_lr));
         check("good_cnt", 32'(good_cnt), 32'(exp_cnt));
         if (load) n_loads++;
      end
   end

   task automatic tick(input logic en, input logic s);
      bit_en = en;
      sin    = s;
      @(posedge clk);
      #1;
      exp_load = 1'b0;
      exp_err  = 1'b0;
   endtask

   // gap < 0: random 0..3 idle cycles before each sample; otherwise fixed gap
   task automatic send_frame(input logic dir, input logic [WIDTH-1:0] d,
                             input logic bad_stop, input logic bad_par, input int gap);
      logic q[$];
      int   g;
      q.push_back(1'b0);
      q.push_back(dir);
      for (int i = 0; i < WIDTH; i++) q.push_back(d[i]);
      if (PAR) q.push_back((^{dir, d}) ^ bad_par);
      q.push_back(~bad_stop);
      for (int i = 0; i < q.size(); i++) begin
         g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
         repeat (g) tick(1'b0, 1'($urandom_range(1, 0)));
         tick(1'b1, q[i]);
         if (i == 0) exp_busy = 1'b1;
         if (i == q.size() - 1) begin
            exp_busy = 1'b0;
            if (!bad_stop && !(PAR && bad_par)) begin
               exp_load = 1'b1;
               exp_data = d;
               exp_lr   = dir;
               if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
            end else begin
               exp_err = 1'b1;
            end
         end
      end
   endtask

   int loads_before;

   initial begin
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      repeat (10) tick(1'b1, 1'b1);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_cnt", 32'(good_cnt), 32'h0);

      send_frame(1'b1, 8'h45, 1'b0, 1'b0, 3);
      check("f45_load", 32'(load), 32'h1);
      check("f45_data", 32'(data_in), 32'h45);
      check("f45_dir", 32'(left_right), 32'h1);
      check("f45_cnt", 32'(good_cnt), 32'h1);
      tick(1'b0, 1'b1);
      check("f45_pulse_end", 32'(load), 32'h0);

      send_frame(1'b0, 8'h32, 1'b1, 1'b0, 1);
      check("f32_err", 32'(frame_err), 32'h1);
      check("f32_noload", 32'(load), 32'h0);
      check("f32_data", 32'(data_in), 32'h45);
      check("f32_cnt", 32'(good_cnt), 32'h1);

      if (PAR) begin
         send_frame(1'b0, 8'h34, 1'b0, 1'b1, 0);
         check("f34p_err", 32'(frame_err), 32'h1);
         check("f34p_noload", 32'(load), 32'h0);
         send_frame(1'b0, 8'h34, 1'b0, 1'b0, 0);
         check("f34_load", 32'(load), 32'h1);
         check("f34_data", 32'(data_in), 32'h34);
         check("f34_dir", 32'(left_right), 32'h0);
      end

      // abort a frame for 8'h50 after its 4th data bit
      tick(1'b1, 1'b0);
      exp_busy = 1'b1;
      tick(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
      #1 rst = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_data", 32'(data_in), 32'h0);
      check("rst_cnt", 32'(good_cnt), 32'h0);
      check("rst_load", 32'(load), 32'h0);
      check("rst_dir", 32'(left_right), 32'h0);
      model_reset();
      bit_en = 1'b0;
      sin    = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;

      send_frame(1'b1, 8'h07, 1'b0, 1'b0, 0);
      check("f07_load", 32'(load), 32'h1);
      check("f07_data", 32'(data_in), 32'h07);
      check("f07_cnt", 32'(good_cnt), 32'h1);

      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(3, 0)) tick(1'($urandom_range(1, 0)), 1'b1);
         send_frame(1'($urandom_range(1, 0)), 8'($urandom), ($urandom_range(4, 0) == 0),
                    ($urandom_range(4, 0) == 0), -1);
      end
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);

      loads_before = n_loads;
      for (int k = 0; k < 260; k++) send_frame(1'($urandom_range(1, 0)), 8'($urandom), 1'b0, 1'b0, 0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      check("sat_cnt", 32'(good_cnt), 32'hFF);
      check("sat_loads", 32'(n_loads - loads_before), 32'd260);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
